// File: rtl/pcie_phys_pkg.sv
// Shared PHY constants: ordered-set K-codes and the serializer state encoding.
package pcie_phys_pkg;

  localparam logic [7:0] K_COM   = 8'hBC;
  localparam logic [7:0] K_SKP   = 8'h1C;
  localparam int         SKP_LEN = 4;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_DATA = 2'd1,
    SER_SKP  = 2'd2
  } ser_state_e;

endpackage

// File: rtl/pcie_sync_fifo.sv
// Single-clock word FIFO with show-ahead read data, full/empty flags and fill level.
module pcie_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_wr, do_rd;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  // Head word is visible combinationally so the consumer can pop and use it in one cycle.
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointer and level update; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd) level_d = level_q + 1'b1;
    if (do_rd && !do_wr) level_d = level_q - 1'b1;
  end

  // Pointer/level registers; storage contents need no reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/mac_frame_serializer.sv
// Buffers MAC words and emits them one byte per accepted cycle, LSB first,
// inserting COM+3xSKP ordered sets on word boundaries at a fixed interval.
module mac_frame_serializer
  import pcie_phys_pkg::*;
#(
  parameter int MAC_FRAME_WIDTH = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int SKP_INTERVAL    = 1180
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [MAC_FRAME_WIDTH-1:0]   mac_data_frame_i,
  input  logic                         mac_data_frame_valid_i,
  output logic                         mac_data_frame_ready_o,
  input  logic                         skp_enable_i,
  output logic [7:0]                   byte_o,
  output logic                         byte_k_o,
  output logic                         byte_valid_o,
  input  logic                         byte_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
  output logic                         skp_pending_o
);

  localparam int BYTES = MAC_FRAME_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CYC_W = $clog2(SKP_INTERVAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SKP_INTERVAL - 1);
  localparam logic [1:0]       SKP_LAST = 2'(SKP_LEN - 1);

  ser_state_e                 state_q, state_d;
  logic [MAC_FRAME_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [1:0]                 skp_cnt_q, skp_cnt_d;
  logic [CYC_W-1:0]           cyc_q, cyc_d;
  logic                       skp_pending_q, skp_pending_d;

  logic                       fifo_full, fifo_empty, fifo_pop;
  logic [MAC_FRAME_WIDTH-1:0] fifo_rd_data;
  logic                       sym_accept, com_accept, skp_due, skp_expiry;

  assign sym_accept = (state_q != SER_IDLE) && byte_ready_i;
  assign com_accept = (state_q == SER_SKP) && (skp_cnt_q == 2'd0) && byte_ready_i;
  // A pending SKP only counts while scheduling is enabled; disabling cancels it at once.
  assign skp_due    = skp_pending_q && skp_enable_i;
  assign skp_expiry = skp_enable_i && (cyc_q == CYC_LAST);

  assign mac_data_frame_ready_o = !fifo_full;
  assign skp_pending_o          = skp_pending_q;

  pcie_sync_fifo #(
    .WIDTH (MAC_FRAME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (mac_data_frame_valid_i && !fifo_full),
    .wr_data_i (mac_data_frame_i),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level_o)
  );

  // SKP scheduler: interval counter and non-accumulating pending flag.
  always_comb begin
    cyc_d         = cyc_q;
    skp_pending_d = skp_pending_q;
    if (!skp_enable_i) begin
      cyc_d         = '0;
      skp_pending_d = 1'b0;
    end else begin
      cyc_d = skp_expiry ? '0 : cyc_q + 1'b1;
      if (com_accept) skp_pending_d = 1'b0;
      if (skp_expiry) skp_pending_d = 1'b1;
    end
  end

  // Serializer next-state and symbol outputs; the word is shifted so byte 0 is always data_q[7:0].
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    idx_d        = idx_q;
    skp_cnt_d    = skp_cnt_q;
    fifo_pop     = 1'b0;
    byte_o       = 8'h00;
    byte_k_o     = 1'b0;
    byte_valid_o = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (skp_due) begin
          state_d   = SER_SKP;
          skp_cnt_d = 2'd0;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_rd_data;
          idx_d    = '0;
          state_d  = SER_DATA;
        end
      end
      SER_DATA: begin
        byte_valid_o = 1'b1;
        byte_o       = data_q[7:0];
        if (sym_accept) begin
          if (idx_q == LAST_IDX) begin
            if (skp_due) begin
              state_d   = SER_SKP;
              skp_cnt_d = 2'd0;
            end else if (!fifo_empty) begin
              fifo_pop = 1'b1;
              data_d   = fifo_rd_data;
              idx_d    = '0;
            end else begin
              state_d = SER_IDLE;
            end
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = data_q >> 8;
          end
        end
      end
      SER_SKP: begin
        byte_valid_o = 1'b1;
        byte_k_o     = 1'b1;
        byte_o       = (skp_cnt_q == 2'd0) ? K_COM : K_SKP;
        if (sym_accept) begin
          if (skp_cnt_q == SKP_LAST) begin
            state_d   = SER_IDLE;
            skp_cnt_d = 2'd0;
          end else begin
            skp_cnt_d = skp_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  // State registers; reset discards any partial word or SKP set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= SER_IDLE;
      data_q        <= '0;
      idx_q         <= '0;
      skp_cnt_q     <= '0;
      cyc_q         <= '0;
      skp_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      idx_q         <= idx_d;
      skp_cnt_q     <= skp_cnt_d;
      cyc_q         <= cyc_d;
      skp_pending_q <= skp_pending_d;
    end
  end

endmodule

// File: doc/mac_frame_serializer.md
# mac_frame_serializer

Width-converting transmit stage between the Data Link Layer MAC interface and `multi_lane_controller`. Buffers incoming MAC frames, emits them one byte per accepted cycle (least-significant byte first), and inserts periodic SKP ordered sets (COM + 3×SKP K-symbols) on word boundaries. Its byte stream is the data-frame input of the lane controller and replaces the current truncating assignment of the MAC frame in the PHY top.

## Interface
- `MAC_FRAME_WIDTH`, 32, input word width in bits; must be a multiple of 8 (BYTES = MAC_FRAME_WIDTH/8).
- `FIFO_DEPTH`, 4, word FIFO depth; power of 2, ≥2.
- `SKP_INTERVAL`, 1180, cycles between SKP scheduling events; ≥8.

Ports:
- `clk_i`  in  1  symbol clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `mac_data_frame_i`  in  MAC_FRAME_WIDTH  MAC word.
- `mac_data_frame_valid_i`  in  1  word valid.
- `mac_data_frame_ready_o`  out  1  word accepted when valid && ready.
- `skp_enable_i`  in  1  enables SKP scheduling.
- `byte_o`  out  8  output symbol.
- `byte_k_o`  out  1  symbol is a K-code.
- `byte_valid_o`  out  1  symbol valid.
- `byte_ready_i`  in  1  downstream accepts symbol.
- `fifo_level_o`  out  $clog2(FIFO_DEPTH)+1  words stored.
- `skp_pending_o`  out  1  SKP scheduled, not yet started.

## Operation
- Input: `mac_data_frame_ready_o` = !full, computed from the level at the start of the cycle. There is no write-through when full, even if a read occurs in the same cycle.
- FSM states: IDLE, DATA, SKP.
  - IDLE: if `skp_pending` → SKP. Else, if FIFO is non-empty → pop a word into the shift register, byte index = 0 → DATA.
  - DATA: presents byte[index], `byte_k_o` = 0. On accept, index increments. On accepting the last byte (index = BYTES-1):
    - `skp_pending` → SKP;
    - else FIFO non-empty → pop the next word, stay in DATA (no bubble);
    - else → IDLE.
  - SKP: emits COM (8'hBC), then SKP (8'h1C) ×3, all with `byte_k_o` = 1. A 2-bit counter advances on each accept. After the 4th accept → IDLE.
- `skp_pending` is cleared when COM is accepted.
- SKP scheduling: a cycle counter runs while `skp_enable_i` = 1. At SKP_INTERVAL-1 it wraps to 0 and sets `skp_pending`. Expiries while already pending do not accumulate.
- `skp_enable_i` = 0: counter and `skp_pending` are cleared immediately. An SKP set already in progress completes.
- Output handshake: `byte_o`/`byte_k_o` stay stable while `byte_valid_o` && !`byte_ready_i`. `byte_valid_o` never drops without an accept, except on reset.

## Timing
- Reset values: `mac_data_frame_ready_o` = 1; `byte_o` = 0; `byte_k_o` = 0; `byte_valid_o` = 0; `fifo_level_o` = 0; `skp_pending_o` = 0. FSM = IDLE, counters = 0.
- Latency: word accepted in cycle N into an empty FIFO with the FSM in IDLE → byte 0 valid in cycle N+2.
- Throughput: 1 byte/cycle with `byte_ready_i` held high. Back-to-back words produce no gap.
- SKP: with `skp_enable_i` high from reset release, the first `skp_pending_o` rises in cycle SKP_INTERVAL. COM appears at the next word boundary, or at IDLE.
- Reset asserted mid-word or mid-SKP: FIFO contents, the partial word and the SKP sequence are discarded. No residue after release.

## Structure
- `pcie_phys_pkg`: `K_COM` = 8'hBC, `K_SKP` = 8'h1C, `SKP_LEN` = 4, FSM enum `ser_state_e`.
- One sub-module: `pcie_sync_fifo`, a parameterised single-clock FIFO (width, depth) with async active-low reset, full/empty flags and level output.

## Test plan
- Single word 32'hDDCCBBAA, `byte_ready_i` = 1, `skp_enable_i` = 0 → bytes AA, BB, CC, DD in cycles N+2…N+5, `byte_k_o` = 0, then `byte_valid_o` = 0.
- FIFO_DEPTH+2 words streamed with `byte_ready_i` = 0 → `mac_data_frame_ready_o` falls once `fifo_level_o` = 4. Releasing ready → all bytes come out in order with no gaps and no lost or duplicated word.
- `byte_ready_i` toggled pseudo-randomly → `byte_o` is stable whenever valid && !ready, and the byte sequence is unchanged.
- SKP_INTERVAL = 16, continuous traffic → BC, 1C, 1C, 1C (K = 1) appear only at word boundaries, once per interval, and `skp_pending_o` clears on COM accept.
- `skp_enable_i` dropped during the 2nd SKP symbol → the set completes (4 symbols), then no further SKP. Re-enabling restarts counting from 0.
- `rst_ni` pulsed low mid-word → all outputs return to their reset values asynchronously. A new word 32'h04030201 after release → 01, 02, 03, 04 only.
